// File: rtl/sd_readout_chunker.sv
// rtl/sd_readout_chunker.sv - FIFO-buffered chunker from 16-bit SD readout words to a byte stream
// Releases CHUNK_WORDS-word chunks high byte first, one byte per out_trigger.
module sd_readout_chunker #(
    parameter int FIFO_AW     = 8,
    parameter int CHUNK_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        flush,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        out_trigger,
    output logic [7:0]  out_data,
    output logic        d_ready,
    output logic        busy,
    output logic        underflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BL_W  = FIFO_AW + 2;
    localparam logic [FIFO_AW:0] DEPTH_CNT   = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] CHUNK_CNT   = (FIFO_AW+1)'(CHUNK_WORDS);
    localparam logic [BL_W-1:0]  CHUNK_BYTES = BL_W'(2 * CHUNK_WORDS);

    typedef enum logic [1:0] {IDLE, READY, XFER} state_t;

    state_t               state;
    logic [15:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     count;
    logic [FIFO_AW:0]     count_next;
    logic [BL_W-1:0]      bytes_left;
    logic [15:0]          head;
    logic                 push;
    logic                 pop;
    logic                 emit;

    assign head = mem[rd_ptr];
    assign push = in_valid && in_ready && !flush;
    assign emit = out_trigger && (state != IDLE);
    // bytes_left starts even, so an odd value marks the low byte of the head word
    assign pop  = emit && bytes_left[0];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + (FIFO_AW+1)'(1);
        else if (pop && !push)
            count_next = count - (FIFO_AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            bytes_left <= '0;
            in_ready   <= 1'b0;
            out_data   <= '0;
            d_ready    <= 1'b0;
            busy       <= 1'b0;
            underflow  <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            bytes_left <= '0;
            in_ready   <= 1'b1;
            out_data   <= '0;
            d_ready    <= 1'b0;
            busy       <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            count    <= count_next;
            in_ready <= (count_next < DEPTH_CNT);

            if (out_trigger && state == IDLE)
                underflow <= 1'b1;

            if (emit) begin
                out_data   <= bytes_left[0] ? head[7:0] : head[15:8];
                bytes_left <= bytes_left - BL_W'(1);
            end

            case (state)
                IDLE: begin
                    if (count >= CHUNK_CNT) begin
                        state      <= READY;
                        d_ready    <= 1'b1;
                        busy       <= 1'b1;
                        bytes_left <= CHUNK_BYTES;
                    end
                end
                READY: begin
                    if (out_trigger) begin
                        state   <= XFER;
                        d_ready <= 1'b0;
                    end
                end
                XFER: begin
                    if (out_trigger && bytes_left == BL_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_readout_chunker.sv
// tb/tb_sd_readout_chunker.sv - scoreboard bench for sd_readout_chunker (FIFO_AW=3, CHUNK_WORDS=4)
module tb_sd_readout_chunker;

    logic        clk = 1'b0;
    logic        rst_;
    logic        flush;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out_trigger;
    logic [7:0]  out_data;
    logic        d_ready;
    logic        busy;
    logic        underflow;

    logic        emit_now;
    logic [7:0]  exp_q[$];
    logic [7:0]  last_exp;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sd_readout_chunker #(.FIFO_AW(3), .CHUNK_WORDS(4)) dut (
        .clk         (clk),
        .rst_        (rst_),
        .flush       (flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_trigger (out_trigger),
        .out_data    (out_data),
        .d_ready     (d_ready),
        .busy        (busy),
        .underflow   (underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stimulus flags each trigger that should produce a byte; the byte appears after that edge.
    initial begin
        logic e;
        last_exp = 8'h00;
        forever begin
            @(posedge clk);
            e = emit_now;
            #1;
            if (e) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_data_unexpected: got %0h expected none", out_data);
                end else begin
                    last_exp = exp_q.pop_front();
                    chk("out_data", {24'h0, out_data}, {24'h0, last_exp});
                end
            end
        end
    end

    task automatic push_word(input logic [15:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", 32'd0, 32'd1);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse(input logic emit);
        out_trigger = 1'b1;
        emit_now    = emit;
        @(negedge clk);
        out_trigger = 1'b0;
        emit_now    = 1'b0;
    endtask

    task automatic wait_dready();
        int n = 0;
        while (!d_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_dready", {31'h0, d_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0;
        out_trigger = 1'b0; emit_now = 1'b0;

        repeat (5) @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
        chk("rst_d_ready", {31'h0, d_ready}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_out_data", {24'h0, out_data}, 32'd0);
        rst_ = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("post_rst_d_ready", {31'h0, d_ready}, 32'd0);
        chk("post_rst_underflow", {31'h0, underflow}, 32'd0);
        chk("post_rst_out_data", {24'h0, out_data}, 32'd0);

        // single chunk
        push_word(16'h1122); push_word(16'h3344); push_word(16'h5566); push_word(16'h7788);
        chk("d_ready_at_threshold", {31'h0, d_ready}, 32'd0);
        @(negedge clk);
        chk("d_ready_set", {31'h0, d_ready}, 32'd1);
        chk("busy_ready", {31'h0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            pulse(1'b1);
            if (i == 0) chk("d_ready_clear", {31'h0, d_ready}, 32'd0);
            if (i == 6) chk("busy_xfer", {31'h0, busy}, 32'd1);
            if (i == 7) chk("busy_done", {31'h0, busy}, 32'd0);
            @(negedge clk);
        end

        // back-pressure
        for (int i = 0; i < 8; i++) push_word({8'hA0 + 8'(i), 8'h50 + 8'(i)});
        chk("full_in_ready", {31'h0, in_ready}, 32'd0);
        in_data = 16'hBEEF; in_valid = 1'b1;
        exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        repeat (3) @(negedge clk);
        chk("held_in_ready", {31'h0, in_ready}, 32'd0);
        chk("full_count", 32'(dut.count), 32'd8);
        pulse(1'b1);
        pulse(1'b1);
        chk("after_pop_in_ready", {31'h0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("refill_in_ready", {31'h0, in_ready}, 32'd0);
        chk("refill_count", 32'(dut.count), 32'd8);
        repeat (6) pulse(1'b1);
        wait_dready();
        repeat (8) pulse(1'b1);
        chk("chunk2_busy_done", {31'h0, busy}, 32'd0);

        // underflow with two words buffered
        push_word(16'h1234);
        chk("pre_underflow", {31'h0, underflow}, 32'd0);
        pulse(1'b0);
        chk("underflow_set", {31'h0, underflow}, 32'd1);
        chk("underflow_out_data", {24'h0, out_data}, {24'h0, last_exp});
        chk("underflow_last_byte", {24'h0, last_exp}, 32'h57);
        chk("underflow_count", 32'(dut.count), 32'd2);
        chk("underflow_d_ready", {31'h0, d_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("underflow_sticky", {31'h0, underflow}, 32'd1);

        // flush after 3 bytes; word offered in flush cycle is dropped
        push_word(16'h5A5A); push_word(16'h6B6B);
        wait_dready();
        repeat (3) pulse(1'b1);
        flush = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        chk("flush_busy", {31'h0, busy}, 32'd0);
        chk("flush_d_ready", {31'h0, d_ready}, 32'd0);
        chk("flush_count", 32'(dut.count), 32'd0);
        chk("flush_underflow", {31'h0, underflow}, 32'd0);
        chk("flush_in_ready", {31'h0, in_ready}, 32'd1);
        chk("flush_out_data", {24'h0, out_data}, 32'd0);

        // asynchronous reset mid-transfer
        pulse(1'b0);
        chk("underflow_again", {31'h0, underflow}, 32'd1);
        push_word(16'h0102); push_word(16'h0304); push_word(16'h0506); push_word(16'h0708);
        wait_dready();
        repeat (3) pulse(1'b1);
        #2 rst_ = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_busy", {31'h0, busy}, 32'd0);
        chk("arst_d_ready", {31'h0, d_ready}, 32'd0);
        chk("arst_count", 32'(dut.count), 32'd0);
        chk("arst_underflow", {31'h0, underflow}, 32'd0);
        chk("arst_in_ready", {31'h0, in_ready}, 32'd0);
        chk("arst_out_data", {24'h0, out_data}, 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        chk("arst_release_in_ready", {31'h0, in_ready}, 32'd1);

        // three chunks streamed across the pointer wrap at 1 byte/clk
        fork
            begin
                for (int i = 0; i < 12; i++) push_word(16'h3000 + 16'(i) * 16'h0111);
            end
            begin
                repeat (3) begin
                    wait_dready();
                    repeat (8) pulse(1'b1);
                end
            end
        join
        @(negedge clk);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);
        chk("stream_underflow", {31'h0, underflow}, 32'd0);
        chk("stream_busy", {31'h0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
